// File: rtl/pc_target_unit_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pc_pkg
// Shared types and constants for the fetch-PC / control-transfer target unit.
//   redirect_sel_t : encoding of the execute-stage redirect source
//   DEFAULT_IALIGN : RV32I instruction alignment in bytes
//   ALIGN_BITS     : number of low PC bits that must be zero at DEFAULT_IALIGN
//   align_mask()   : mask of the low address bits that must be zero
// ----------------------------------------------------------------------------
package riscv_pc_pkg;

    typedef enum logic [1:0] {
        SEL_BR   = 2'b00,   // branch / JAL, PC-relative
        SEL_JALR = 2'b01,   // register-indirect, bit 0 cleared
        SEL_TRAP = 2'b10    // trap handler (mtvec)
    } redirect_sel_t;

    localparam int DEFAULT_IALIGN = 4;
    localparam int ALIGN_BITS     = $clog2(DEFAULT_IALIGN);

    // Mask of the address bits that must be zero for a fetch address to be
    // aligned at the given instruction alignment (ialign is a power of two).
    function automatic logic [31:0] align_mask(input int ialign);
        return 32'(ialign - 1);
    endfunction

endpackage : riscv_pc_pkg

// File: rtl/pc_target_unit_ras.sv
// ----------------------------------------------------------------------------
// pc_ras
// Circular return-address stack. Only instantiated when PC_RAS_EN is defined.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   push_i        : write push_data_i as the new top (call)
//   pop_i         : discard the top entry (return)
//   push_data_i   : return address to push
//   top_o         : current top entry, 0 when empty
//   valid_o       : stack holds at least one entry
// A push into a full stack overwrites the oldest entry and the count stays
// saturated. Push and pop together replace the top in place.
// ----------------------------------------------------------------------------
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   tp_q, tp_d;     // index of the current top entry
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic            empty;

    assign empty = (cnt_q == '0);

    always_comb begin
        tp_d   = tp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = tp_q;
        if (push_i && pop_i) begin
            // Replace top in place; depth does not change.
            wr_en  = 1'b1;
            wr_idx = tp_q;
        end else if (push_i) begin
            // Pointer wraps naturally, so a full stack overwrites its oldest slot.
            wr_en  = 1'b1;
            wr_idx = tp_q + 1'b1;
            tp_d   = tp_q + 1'b1;
            if (cnt_q != CW'(RAS_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && !empty) begin
            tp_d  = tp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q  <= '0;
            cnt_q <= '0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while cnt_q != 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o   = empty ? '0 : mem_q[tp_q];
    assign valid_o = !empty;

endmodule : pc_ras

// File: rtl/pc_target_unit.sv
// ----------------------------------------------------------------------------
// pc_target_unit
// Owns the fetch PC. Computes the sequential successor and the execute-stage
// control-transfer target (branch/JAL, JALR, trap), applies redirects, stalls
// and misalignment traps.
// Optional feature macro: PC_RAS_EN (adds a return-address stack, pc_ras).
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   stall_i           : hold the fetch PC
//   redirect_i        : taken control transfer resolved in execute
//   redirect_sel_i    : 00 branch/JAL, 01 JALR, 10 trap, 11 treated as 00
//   pc_e_i, imm_ext_i : execute PC and sign-extended immediate
//   rs1_i             : JALR base register
//   trap_vec_i        : trap handler address
//   ras_push_i/pop_i  : RAS call/return (ignored without PC_RAS_EN)
//   pc_o, pc_valid_o  : registered fetch PC and its valid flag
//   pc_plus_o         : pc_o + IALIGN
//   pc_target_o       : selected target (combinational)
//   misalign_o        : one-cycle pulse after a misaligned redirect
//   misalign_addr_o   : last misaligned target
//   ras_top_o/valid_o : predicted return address / RAS non-empty
// ----------------------------------------------------------------------------
module pc_target_unit
    import riscv_pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [1:0]      redirect_sel_i,
    input  logic [XLEN-1:0] pc_e_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            ras_push_i,
    input  logic            ras_pop_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_valid_o
);

    localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(IALIGN));

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    logic [XLEN-1:0] target;
    logic            tgt_misaligned;

    // Target selection; reserved encoding 11 behaves as PC-relative.
    always_comb begin
        target = pc_e_i + imm_ext_i;
        case (redirect_sel_i)
            SEL_JALR: target = (rs1_i + imm_ext_i) & ~XLEN'(1);
            SEL_TRAP: target = trap_vec_i;
            default:  target = pc_e_i + imm_ext_i;
        endcase
    end

    // Trap vector targets are trusted and never checked.
    assign tgt_misaligned = (redirect_sel_i != SEL_TRAP) && ((target & MASK) != '0);

    // Redirect wins over stall so a flush is never dropped.
    always_comb begin
        pc_d    = pc_q;
        valid_d = 1'b1;
        mis_d   = 1'b0;
        maddr_d = maddr_q;
        if (redirect_i) begin
            if (tgt_misaligned) begin
                pc_d    = trap_vec_i;
                mis_d   = 1'b1;
                maddr_d = target;
            end else begin
                pc_d = target;
            end
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (valid_q) begin
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = valid_q;
    assign pc_plus_o       = pc_q + STEP;
    assign pc_target_o     = target;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = maddr_q;

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push_i),
        .pop_i       (ras_pop_i),
        .push_data_i (pc_e_i + STEP),
        .top_o       (ras_top_o),
        .valid_o     (ras_valid_o)
    );
`else
    logic unused_ras;
    assign unused_ras  = ras_push_i ^ ras_pop_i;
    assign ras_top_o   = '0;
    assign ras_valid_o = 1'b0;
`endif

endmodule : pc_target_unit
